ps2_key_event_rx: RTL and testbench
===================================

# ps2_key_event_rx

Fully synchronous PS/2 keyboard receiver that turns raw `kclk`/`kdata` lines into decoded key events (`make`/`break`, extended flag, 8-bit scancode) and buffers them in a small FIFO with a valid/ready interface. It is the next generation of the keyboard front end: it adds parity and stop-bit checking, frame timeout recovery, E0/F0 prefix decoding and back-pressure. It sits between the PS/2 pins and the keypress consumer (rotor/plugboard logic).

## Interface
- `FILTER_LEN`, default 19: consecutive equal samples needed before a filtered line changes.
- `TIMEOUT_CYC`, default 100000: idle cycles (no kclk falling edge) that abort a partial frame.
- `FIFO_DEPTH`, default 8: number of event entries; power of two, ≥2.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `kclk` in 1: raw PS/2 clock, asynchronous.
- `kdata` in 1: raw PS/2 data, asynchronous.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head this cycle.
- `ev_code` out 8: scancode of the head event.
- `ev_ext` out 1: head event was E0-prefixed.
- `ev_brk` out 1: head event was F0-prefixed (key release).
- `frame_err` out 1: one-cycle pulse on parity, stop or timeout error.
- `overflow` out 1: one-cycle pulse when a completed event is dropped because the FIFO is full.

## Operation
- Each input passes through a 2-FF synchroniser, then a filter counter. The filtered output takes the synchronised value after `FILTER_LEN` consecutive equal samples. Any mismatch restarts the count. The filtered outputs reset to 1.
- A kclk falling edge is detected in the `clk` domain: filtered value was 1 last cycle and is 0 this cycle. All frame logic advances only on this edge pulse.
- Frame FSM states:
  - IDLE: on an edge, data=0 → DATA with the bit counter set to 0. Data=1 is an invalid start bit; stay in IDLE with no error.
  - DATA: shift the bit into `sr[7:0]`, LSB first. After 8 bits → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: check the frame → IDLE.
- Frame check:
  - Valid requires an odd total of ones across the 8 data bits plus the parity bit, and stop bit = 1.
  - Any failure pulses `frame_err`, clears the prefix flags and produces no event.
- Timeout: the timer counts in any non-IDLE state and clears on each edge. At `TIMEOUT_CYC` the FSM returns to IDLE, pulses `frame_err` and clears the prefix flags.
- Prefix decoding of valid bytes:
  - 0xE0 sets `ext_pend`.
  - 0xF0 sets `brk_pend`.
  - Any other byte pushes `{ext_pend, brk_pend, byte}` and clears both flags.
- FIFO:
  - First-word fall-through; the head is valid on the outputs whenever `ev_valid`=1.
  - A pop occurs on `ev_valid & ev_ready`.
  - A push to a full FIFO with no simultaneous pop is dropped and pulses `overflow`.
  - A push and a pop in the same cycle while full are both accepted.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy is held in log2(`FIFO_DEPTH`)+1 bits.
- Reset values:
  - `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_brk`=0, `frame_err`=0, `overflow`=0.
  - FSM=IDLE; counters, prefix flags and FIFO pointers all 0.
  - Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Pin to filtered line: 2 + `FILTER_LEN` cycles. The edge pulse comes 1 cycle later.
- Stop-bit edge pulse at cycle N:
  - Frame check and push happen at N+1.
  - `ev_valid` rises at N+2 if the FIFO was empty.
  - `frame_err` or `overflow` is high for cycle N+1 only.
- Pop at cycle M: the next entry, or `ev_valid`=0, is visible at M+1.
- A timeout fires on the cycle the counter reaches `TIMEOUT_CYC`. If an edge arrives in the same cycle, the edge wins and the counter clears.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_EXT=8'hE0` and `PS2_BRK=8'hF0`.
  - Event struct `{ext, brk, code[7:0]}`.
- Sub-module `ps2_line_filter` (synchroniser plus filter counter, parameter `FILTER_LEN`), instantiated twice. The FIFO is inline.

## Test plan
- Send key 0x1C (parity 0, stop 1) with `ev_ready`=1 → one event: code=0x1C, ext=0, brk=0; `frame_err` stays 0.
- Send bytes E0, F0, 74 → exactly one event: code=0x74, ext=1, brk=1. A following 0x1C has ext=0, brk=0.
- Send 0x1C with parity=1 → `frame_err` pulses 1 cycle, no event. A following valid 0x32 is received correctly.
- Send F0, then 4 data bits, then silence for `TIMEOUT_CYC` cycles → `frame_err` pulse and FSM back in IDLE. A next valid 0x15 gives brk=0.
- `FIFO_DEPTH`=4, `ev_ready`=0, send 5 keys → the 5th pulses `overflow`. Draining yields the first 4 codes in order, then `ev_valid`=0.
- Apply 5-cycle kclk glitches with `FILTER_LEN`=19 → no edge detected and no state change. Assert `rst` mid-DATA → all outputs at reset values, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser followed by a run-length filter.
// The output follows the synchronised input only after FILTER_LEN agreeing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame decode with parity/stop/timeout checks,
// E0/F0 prefix folding and a first-word fall-through event FIFO.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 19,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic kclk_f, kdata_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_clk (
    .clk(clk), .rst(rst), .din(kclk), .dout(kclk_f));

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_dat (
    .clk(clk), .rst(rst), .din(kdata), .dout(kdata_f));

  // Registered fall detect; kd is the data level seen on the same sample.
  logic kclk_d, edge_p, kd;

  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_d <= 1'b1;
      edge_p <= 1'b0;
      kd     <= 1'b1;
    end else begin
      kclk_d <= kclk_f;
      edge_p <= kclk_d & ~kclk_f;
      kd     <= kdata_f;
    end
  end

  ps2_state_t    state, state_n;
  logic [2:0]    bitcnt;
  logic [7:0]    sr;
  logic          par;
  logic [TW-1:0] tmr;
  logic          tmo, stop_edge, frame_ok;
  logic          ext_pend, brk_pend;
  logic          push_q;
  ps2_ev_t       ev_d;

  assign tmo       = (state != ST_IDLE) && !edge_p && (tmr == TW'(TIMEOUT_CYC - 1));
  assign stop_edge = edge_p && (state == ST_STOP);
  assign frame_ok  = (^{par, sr}) & kd;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (edge_p && !kd) state_n = ST_DATA;
      ST_DATA:   if (edge_p && bitcnt == 3'd7) state_n = ST_PARITY;
      ST_PARITY: if (edge_p) state_n = ST_STOP;
      ST_STOP:   if (edge_p) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (tmo) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      sr        <= '0;
      par       <= 1'b0;
      tmr       <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
      push_q    <= 1'b0;
      ev_d      <= '0;
    end else begin
      state     <= state_n;
      frame_err <= 1'b0;
      push_q    <= 1'b0;
      tmr       <= (edge_p || state == ST_IDLE || tmo) ? '0 : tmr + 1'b1;

      if (edge_p) begin
        case (state)
          ST_IDLE:   bitcnt <= '0;
          ST_DATA: begin
            sr     <= {kd, sr[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          ST_PARITY: par <= kd;
          default: ;
        endcase
      end

      if (stop_edge) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end else if (sr == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (sr == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          push_q   <= 1'b1;
          ev_d     <= '{ext: ext_pend, brk: brk_pend, code: sr};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end

      if (tmo) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end
    end
  end

  // Event FIFO, head shown directly on the outputs.
  ps2_ev_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, pop, wr;
  ps2_ev_t       head;

  assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (cnt != '0);
  assign pop      = ev_valid & ev_ready;
  assign wr       = push_q & (~full | pop);
  assign overflow = push_q & full & ~pop;
  assign head     = mem[rp];
  assign ev_code  = ev_valid ? head.code : 8'h00;
  assign ev_ext   = ev_valid & head.ext;
  assign ev_brk   = ev_valid & head.brk;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= ev_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: framing, prefixes, errors, overflow, glitches, reset.
module tb_ps2_key_event_rx;

  localparam int FILTER_LEN  = 19;
  localparam int TIMEOUT_CYC = 3000;
  localparam int FIFO_DEPTH  = 4;
  localparam int HALF        = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, frame_err, overflow;
  logic [7:0] ev_code;

  int n_vec = 0;
  int n_miss = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] evq[$];

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_brk(ev_brk), .frame_err(frame_err), .overflow(overflow));

  // Record accepted events and error pulse cycles.
  always @(negedge clk) begin
    if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_brk, ev_code});
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kdata = b;
    cyc(HALF);
    kclk = 1'b0;
    cyc(HALF);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_flip);
    send_bit(1'b1);
    kdata = 1'b1;
    cyc(2 * HALF);
  endtask

  initial begin
    cyc(5);
    @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_flags", 32'({ev_ext, ev_brk}), 0);
    chk("rst_pulses", 32'({frame_err, overflow}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ev_ready = 1'b1;
    cyc(10);

    // Plain key
    send_frame(8'h1C, 1'b0);
    chk("key_count", 32'(evq.size()), 1);
    chk("key_ev", 32'(evq[0]), 32'h01C);
    chk("key_ferr", 32'(ferr_cnt), 0);
    evq.delete();

    // Extended release, then a plain key
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("pfx_count", 32'(evq.size()), 2);
    chk("pfx_ev0", 32'(evq[0]), 32'h374);
    chk("pfx_ev1", 32'(evq[1]), 32'h01C);
    evq.delete();

    // Parity error
    send_frame(8'h1C, 1'b1);
    chk("par_ferr", 32'(ferr_cnt), 1);
    chk("par_noev", 32'(evq.size()), 0);
    send_frame(8'h32, 1'b0);
    chk("par_next", 32'(evq[0]), 32'h032);
    chk("par_ferr2", 32'(ferr_cnt), 1);
    evq.delete();

    // Timeout with a pending break prefix
    send_frame(8'hF0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    kdata = 1'b1;
    cyc(TIMEOUT_CYC + 200);
    chk("tmo_ferr", 32'(ferr_cnt), 2);
    chk("tmo_noev", 32'(evq.size()), 0);
    send_frame(8'h15, 1'b0);
    chk("tmo_next", 32'(evq[0]), 32'h015);
    chk("tmo_ferr2", 32'(ferr_cnt), 2);
    evq.delete();

    // Overflow with consumer stalled
    @(negedge clk); ev_ready = 1'b0;
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'h15, 1'b0);
    send_frame(8'h24, 1'b0);
    chk("ovf_none", 32'(ovf_cnt), 0);
    send_frame(8'h2D, 1'b0);
    chk("ovf_pulse", 32'(ovf_cnt), 1);
    @(negedge clk);
    chk("ovf_valid", 32'(ev_valid), 1);
    chk("ovf_head", 32'(ev_code), 32'h1C);
    ev_ready = 1'b1;
    cyc(10);
    chk("drn_count", 32'(evq.size()), 4);
    chk("drn_ev0", 32'(evq[0]), 32'h01C);
    chk("drn_ev1", 32'(evq[1]), 32'h032);
    chk("drn_ev2", 32'(evq[2]), 32'h015);
    chk("drn_ev3", 32'(evq[3]), 32'h024);
    @(negedge clk);
    chk("drn_empty", 32'(ev_valid), 0);
    evq.delete();

    // Short glitches on both lines must be ignored
    for (int i = 0; i < 6; i++) begin
      kclk = 1'b0; kdata = 1'b0;
      cyc(5);
      kclk = 1'b1; kdata = 1'b1;
      cyc(30);
    end
    cyc(100);
    chk("gl_noev", 32'(evq.size()), 0);
    chk("gl_ferr", 32'(ferr_cnt), 2);
    send_frame(8'h1C, 1'b0);
    chk("gl_next", 32'(evq[0]), 32'h01C);
    evq.delete();

    // Reset mid-frame with a queued event
    @(negedge clk); ev_ready = 1'b0;
    send_frame(8'h24, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    kdata = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("mrst_valid", 32'(ev_valid), 0);
    chk("mrst_code", 32'(ev_code), 0);
    chk("mrst_flags", 32'({ev_ext, ev_brk}), 0);
    chk("mrst_pulses", 32'({frame_err, overflow}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ev_ready = 1'b1;
    cyc(50);
    chk("mrst_noev", 32'(evq.size()), 0);
    send_frame(8'h2D, 1'b0);
    chk("mrst_count", 32'(evq.size()), 1);
    chk("mrst_next", 32'(evq[0]), 32'h02D);
    chk("mrst_ferr", 32'(ferr_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
